ssd_debug_display: RTL and testbench

Downstream FPGA front-end for the single-cycle RV32 datapath. Selects one of the datapath's 32-bit debug buses via board switches, shows 16 bits of it in hex on a 4-digit multiplexed seven-segment display, and mirrors the control-signal word on LEDs. It also debounces the step push-button into a one-cycle `step_pulse` that the board top uses as the datapath's single-step clock enable.

---
 rtl/ssd_debug_display_pkg.sv | 39 +++
 rtl/ssd_debug_display_btn_debouncer.sv | 65 ++++++
 rtl/ssd_debug_display.sv | 191 +++++++++++++++++++
 tb/tb_ssd_debug_display.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_debug_display_pkg.sv
// Shared constants for the seven-segment debug display.
// Holds the source-select codes, the sixteen hex glyphs and the blank pattern.
// Glyphs are active-low and ordered {g,f,e,d,c,b,a}.
package ssd_debug_display_pkg;

    localparam logic [3:0] SEL_INSTR         = 4'd0;
    localparam logic [3:0] SEL_PC_IN         = 4'd1;
    localparam logic [3:0] SEL_PC_4          = 4'd2;
    localparam logic [3:0] SEL_BRANCH_TARGET = 4'd3;
    localparam logic [3:0] SEL_PC_NEXT       = 4'd4;
    localparam logic [3:0] SEL_RS1           = 4'd5;
    localparam logic [3:0] SEL_RS2           = 4'd6;
    localparam logic [3:0] SEL_WRITE_DATA    = 4'd7;
    localparam logic [3:0] SEL_IMM           = 4'd8;
    localparam logic [3:0] SEL_SHIFT_OUT     = 4'd9;
    localparam logic [3:0] SEL_ALU_B         = 4'd10;
    localparam logic [3:0] SEL_ALU_RESULT    = 4'd11;
    localparam logic [3:0] SEL_DMEM_DATA     = 4'd12;
    localparam logic [3:0] SEL_CONTROL       = 4'd13;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/ssd_debug_display_btn_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and
// rising-edge detector on the accepted level. Emits a one-cycle pulse
// each time the accepted level goes from 0 to 1.
module btn_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic             pulse_r;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing cycles; flip the accepted level once stable long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            cnt_r <= '0;
        end
    end

    // Registered rising-edge detect on the accepted level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d_r <= 1'b0;
            pulse_r   <= 1'b0;
        end else begin
            level_d_r <= level_r;
            pulse_r   <= level_r & ~level_d_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/ssd_debug_display.sv
// Seven-segment debug front-end for the single-cycle RV32 datapath.
// Picks a debug bus with sel, shows a 16-bit half of it on a 4-digit
// multiplexed display, mirrors control_in on LEDs and debounces the step button.
// Optional feature: define SSD_LEADING_ZERO_BLANK_EN to blank leading-zero
// digits 3..1 (digit 0 always shows).
module ssd_debug_display
    import ssd_debug_display_pkg::*;
#(
    parameter int REFRESH_BITS    = 18,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in_bus,
    input  logic [31:0] pc_4,
    input  logic [31:0] branch_target,
    input  logic [31:0] pc_next,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] write_data,
    input  logic [31:0] imm,
    input  logic [31:0] shift_out,
    input  logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic [31:0] dmem_data,
    input  logic [15:0] control_in,
    input  logic [3:0]  sel,
    input  logic        half_sel,
    input  logic        step_btn,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic [15:0] leds,
    output logic        step_pulse
);

    localparam logic [REFRESH_BITS-1:0] SCAN_ONE = REFRESH_BITS'(1);

    logic [31:0]             bus_s;
    logic [15:0]             half_s;
    logic [15:0]             disp_word_r;
    logic [REFRESH_BITS-1:0] scan_cnt_r;
    logic [1:0]              digit_s;
    logic [3:0]              nibble_s;
    logic [3:0]              anode_s;
    logic                    blank_s;
    logic [3:0]              anode_r;
    logic [6:0]              seg_r;
    logic [15:0]             leds_r;

    // Hex nibble to active-low glyph.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = SEG_0;
            4'h1:    g = SEG_1;
            4'h2:    g = SEG_2;
            4'h3:    g = SEG_3;
            4'h4:    g = SEG_4;
            4'h5:    g = SEG_5;
            4'h6:    g = SEG_6;
            4'h7:    g = SEG_7;
            4'h8:    g = SEG_8;
            4'h9:    g = SEG_9;
            4'hA:    g = SEG_A;
            4'hB:    g = SEG_B;
            4'hC:    g = SEG_C;
            4'hD:    g = SEG_D;
            4'hE:    g = SEG_E;
            4'hF:    g = SEG_F;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Source bus multiplexer; unused codes show zero.
    always_comb begin
        bus_s = 32'h0;
        case (sel)
            SEL_INSTR:         bus_s = instr_in;
            SEL_PC_IN:         bus_s = pc_in_bus;
            SEL_PC_4:          bus_s = pc_4;
            SEL_BRANCH_TARGET: bus_s = branch_target;
            SEL_PC_NEXT:       bus_s = pc_next;
            SEL_RS1:           bus_s = rs1_data;
            SEL_RS2:           bus_s = rs2_data;
            SEL_WRITE_DATA:    bus_s = write_data;
            SEL_IMM:           bus_s = imm;
            SEL_SHIFT_OUT:     bus_s = shift_out;
            SEL_ALU_B:         bus_s = alu_b;
            SEL_ALU_RESULT:    bus_s = alu_result;
            SEL_DMEM_DATA:     bus_s = dmem_data;
            SEL_CONTROL:       bus_s = {16'h0000, control_in};
            default:           bus_s = 32'h0;
        endcase
    end

    // Pick the displayed 16-bit half.
    always_comb begin
        if (half_sel) begin
            half_s = bus_s[31:16];
        end else begin
            half_s = bus_s[15:0];
        end
    end

    // Per-digit nibble, anode pattern and leading-zero blank decision.
    always_comb begin
        nibble_s = 4'h0;
        anode_s  = 4'b1111;
        blank_s  = 1'b0;
        case (digit_s)
            2'd0: begin
                nibble_s = disp_word_r[3:0];
                anode_s  = 4'b1110;
            end
            2'd1: begin
                nibble_s = disp_word_r[7:4];
                anode_s  = 4'b1101;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank_s  = (disp_word_r[15:4] == 12'h000);
`else
                blank_s  = 1'b0;
`endif
            end
            2'd2: begin
                nibble_s = disp_word_r[11:8];
                anode_s  = 4'b1011;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank_s  = (disp_word_r[15:8] == 8'h00);
`else
                blank_s  = 1'b0;
`endif
            end
            2'd3: begin
                nibble_s = disp_word_r[15:12];
                anode_s  = 4'b0111;
`ifdef SSD_LEADING_ZERO_BLANK_EN
                blank_s  = (disp_word_r[15:12] == 4'h0);
`else
                blank_s  = 1'b0;
`endif
            end
            default: begin
                nibble_s = 4'h0;
                anode_s  = 4'b1111;
                blank_s  = 1'b0;
            end
        endcase
    end

    assign digit_s = scan_cnt_r[REFRESH_BITS-1:REFRESH_BITS-2];

    // Display word capture and free-running scan counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_word_r <= 16'h0000;
            scan_cnt_r  <= '0;
        end else begin
            disp_word_r <= half_s;
            scan_cnt_r  <= scan_cnt_r + SCAN_ONE;
        end
    end

    // Output registers: anode and seg update together so no ghost cycle appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_r <= 4'b1111;
            seg_r   <= SEG_BLANK;
            leds_r  <= 16'h0000;
        end else begin
            anode_r <= anode_s;
            seg_r   <= blank_s ? SEG_BLANK : hex_to_seg(nibble_s);
            leds_r  <= control_in;
        end
    end

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debouncer (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(step_btn),
        .pulse  (step_pulse)
    );

    assign anode = anode_r;
    assign seg   = seg_r;
    assign leds  = leds_r;

endmodule

// File: tb/tb_ssd_debug_display.sv
// Directed testbench for ssd_debug_display with REFRESH_BITS=4, DEBOUNCE_CYCLES=4.
// Expectations follow SSD_LEADING_ZERO_BLANK_EN when it is defined.
module tb_ssd_debug_display;

    localparam logic [6:0] G0 = 7'h40;
    localparam logic [6:0] G1 = 7'h79;
    localparam logic [6:0] G2 = 7'h24;
    localparam logic [6:0] G3 = 7'h30;
    localparam logic [6:0] G4 = 7'h19;
    localparam logic [6:0] GA = 7'h08;
    localparam logic [6:0] GB = 7'h03;
    localparam logic [6:0] GC = 7'h46;
    localparam logic [6:0] GD = 7'h21;
    localparam logic [6:0] GF = 7'h0E;
    localparam logic [6:0] GX = 7'h7F;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = 32'h0, pc_in_bus = 32'h0, pc_4 = 32'h0, branch_target = 32'h0;
    logic [31:0] pc_next = 32'h0, rs1_data = 32'h0, rs2_data = 32'h0, write_data = 32'h0;
    logic [31:0] imm = 32'h0, shift_out = 32'h0, alu_b = 32'h0, alu_result = 32'h0;
    logic [31:0] dmem_data = 32'h0;
    logic [15:0] control_in = 16'h0;
    logic [3:0]  sel = 4'd0;
    logic        half_sel = 1'b0;
    logic        step_btn = 1'b0;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [15:0] leds;
    logic        step_pulse;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ssd_debug_display #(.REFRESH_BITS(4), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .instr_in(instr_in), .pc_in_bus(pc_in_bus), .pc_4(pc_4),
        .branch_target(branch_target), .pc_next(pc_next),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .write_data(write_data),
        .imm(imm), .shift_out(shift_out), .alu_b(alu_b),
        .alu_result(alu_result), .dmem_data(dmem_data),
        .control_in(control_in), .sel(sel), .half_sel(half_sel),
        .step_btn(step_btn), .anode(anode), .seg(seg), .leds(leds),
        .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (anode !== 4'b1111 || seg !== GX || leds !== 16'h0 || step_pulse !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: anode=%b seg=%b leds=%h pulse=%b, want 1111 1111111 0000 0",
                         anode, seg, leds, step_pulse);
            end
        end
        reset = 1'b0;
        cyc = 0;
        tick();
        checks++;
        if (anode !== 4'b1110 || seg !== G0) begin
            failures++;
            $display("FAIL reset_first: anode=%b seg=%b, want 1110 %b", anode, seg, G0);
        end
    endtask

    task automatic test_scan();
        logic [6:0] lo[4];
        logic [6:0] hi[4];
        int d;
        lo = '{GD, GC, GB, GA};
        hi = '{G4, G3, G2, G1};
        sel = 4'd11;
        alu_result = 32'h1234_ABCD;
        for (int h = 0; h < 2; h++) begin
            half_sel = (h == 1);
            tick();
            tick();
            for (int i = 0; i < 16; i++) begin
                tick();
                d = ((cyc - 1) / 4) % 4;
                checks++;
                if (anode !== ~(4'b0001 << d) || seg !== (h == 1 ? hi[d] : lo[d])) begin
                    failures++;
                    $display("FAIL scan half=%0d digit=%0d: anode=%b seg=%b, want %b %b",
                             h, d, anode, seg, ~(4'b0001 << d), (h == 1 ? hi[d] : lo[d]));
                end
            end
        end
        half_sel = 1'b0;
    endtask

    task automatic test_control();
        logic [6:0] exp_g[4];
        int d;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        exp_g = '{G0, GF, GX, GX};
`else
        exp_g = '{G0, GF, G0, G0};
`endif
        sel = 4'd13;
        control_in = 16'h00F0;
        tick();
        tick();
        for (int i = 0; i < 16; i++) begin
            tick();
            d = ((cyc - 1) / 4) % 4;
            checks++;
            if (anode !== ~(4'b0001 << d) || seg !== exp_g[d] || leds !== 16'h00F0) begin
                failures++;
                $display("FAIL control digit=%0d: anode=%b seg=%b leds=%h, want %b %b 00f0",
                         d, anode, seg, leds, ~(4'b0001 << d), exp_g[d]);
            end
        end
    endtask

    task automatic test_unused_sel();
        logic [6:0] exp_g[4];
        int d;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        exp_g = '{G0, GX, GX, GX};
`else
        exp_g = '{G0, G0, G0, G0};
`endif
        instr_in = 32'hFFFF_FFFF; alu_result = 32'hFFFF_FFFF; dmem_data = 32'hFFFF_FFFF;
        control_in = 16'hFFFF;
        for (int s = 14; s <= 15; s++) begin
            sel = 4'(s);
            tick();
            tick();
            for (int i = 0; i < 16; i++) begin
                tick();
                d = ((cyc - 1) / 4) % 4;
                checks++;
                if (seg !== exp_g[d]) begin
                    failures++;
                    $display("FAIL unused_sel%0d digit=%0d: seg=%b, want %b", s, d, seg, exp_g[d]);
                end
            end
        end
    endtask

    task automatic test_sel_latency();
        branch_target = 32'h0000_1111;
        pc_next = 32'h0000_2222;
        sel = 4'd3;
        for (int i = 0; i < 5; i++) tick();
        sel = 4'd4;
        tick();
        checks++;
        if (seg !== G1) begin
            failures++;
            $display("FAIL sel_latency_1: seg=%b, want %b", seg, G1);
        end
        tick();
        checks++;
        if (seg !== G2) begin
            failures++;
            $display("FAIL sel_latency_2: seg=%b, want %b", seg, G2);
        end
    endtask

    task automatic test_btn_glitch();
        int n = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 4) step_btn = 1'b0;
            tick();
            if (step_pulse === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL btn_glitch: pulses=%0d, want 0", n);
        end
    endtask

    task automatic test_btn_hold();
        int n = 0;
        int first = 0;
        step_btn = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            if (i == 21) step_btn = 1'b0;
            tick();
            if (step_pulse === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL btn_hold_count: pulses=%0d, want 1", n);
        end
        checks++;
        if (first != 7) begin
            failures++;
            $display("FAIL btn_hold_latency: first pulse at %0d, want 7", first);
        end
    endtask

    task automatic test_btn_reset();
        int n = 0;
        int first = 0;
        step_btn = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (step_pulse !== 1'b0) begin
                failures++;
                $display("FAIL btn_reset_hold: pulse=%b, want 0", step_pulse);
            end
        end
        reset = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (step_pulse === 1'b1) begin
                n++;
                if (first == 0) first = i;
            end
        end
        checks++;
        if (n != 1 || first != 7) begin
            failures++;
            $display("FAIL btn_after_reset: pulses=%0d first=%0d, want 1 at 7", n, first);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) tick();
    endtask

    task automatic test_async_reset();
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (anode !== 4'b1111 || seg !== GX || leds !== 16'h0) begin
            failures++;
            $display("FAIL async_reset: anode=%b seg=%b leds=%h, want 1111 1111111 0000",
                     anode, seg, leds);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        tick();
        checks++;
        if (anode !== 4'b1110) begin
            failures++;
            $display("FAIL async_reset_release: anode=%b, want 1110", anode);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_control();
        test_unused_sel();
        test_sel_latency();
        test_btn_glitch();
        test_btn_hold();
        test_btn_reset();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
